// File: rtl/mastermind_game.sv
// MasterMind game engine: button pulses -> guess editing, peg scoring and
// VIDEORAM board writes (3 words per row, status word at addr 15).
module mastermind_game #(
  parameter int ROWS = 5,
  parameter int PEGS = 4
) (
  input  logic        CLK_PLL,
  input  logic        RST_N,
  input  logic        NEW_GAME,
  input  logic [11:0] SECRET,
  input  logic        BTN_NEXT,
  input  logic        BTN_MOVE,
  input  logic        BTN_SUBMIT,
  output logic [3:0]  RAM_WADDR,
  output logic [5:0]  RAM_WDATA,
  output logic        RAM_WEN,
  output logic [1:0]  CURSOR,
  output logic [2:0]  ROW,
  output logic [2:0]  HITS,
  output logic [2:0]  MISSES,
  output logic [1:0]  GAME_STATE,
  output logic        BUSY
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_EDIT, S_SCORE, S_RESULT, S_FINISH, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [PEGS-1:0][2:0]   secret_q, secret_d, guess_q, guess_d;
  logic [1:0]             cursor_q, cursor_d, gstate_q, gstate_d;
  logic [2:0]             row_q, row_d, sc_q, sc_d, black_q, black_d, sum_q, sum_d;
  logic [2:0]             hits_q, hits_d, misses_q, misses_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [3:0]             waddr_q, waddr_d;
  logic [5:0]             wdata_q, wdata_d;
  logic                   wen_q, wen_d, busy_q, busy_d;
  logic [2:0]             col, cg, cs, mn, blk, sum_nx, fld;

  function automatic logic [3:0] word_addr(input logic [2:0] r, input logic w);
    return {r, 1'b0} + 4'(r) + 4'(w);
  endfunction

  // Per-colour count terms for the serial min-count accumulation
  always_comb begin
    col = sc_q - 3'd1;
    cg  = '0;
    cs  = '0;
    blk = '0;
    for (int k = 0; k < PEGS; k++) begin
      if (guess_q[k] == col)  cg = cg + 3'd1;
      if (secret_q[k] == col) cs = cs + 3'd1;
      if (guess_q[k] == secret_q[k]) blk = blk + 3'd1;
    end
    mn     = (cg < cs) ? cg : cs;
    sum_nx = sum_q + mn;
  end

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    cursor_d = cursor_q;
    row_d    = row_q;
    sc_d     = sc_q;
    black_d  = black_q;
    sum_d    = sum_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    gstate_d = gstate_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    fld      = '0;
    if (NEW_GAME) begin
      for (int k = 0; k < PEGS; k++) begin
        fld = SECRET[3*k +: 3];
        secret_d[k] = (fld >= 3'd6) ? fld - 3'd6 : fld;
      end
      state_d  = S_CLEAR;
      guess_d  = '0;
      cursor_d = '0;
      row_d    = '0;
      hits_d   = '0;
      misses_d = '0;
      gstate_d = 2'd0;
      cnt_d    = 5'd1;
      wen_d    = 1'b1;
      waddr_d  = 4'd0;
      wdata_d  = 6'd0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          // cnt 1..15 zero-fills, 16 writes the status word, 17 hands over
          if (cnt_q < 5'd16) begin
            wen_d   = 1'b1;
            waddr_d = cnt_q[3:0];
            wdata_d = 6'd0;
            cnt_d   = cnt_q + 5'd1;
          end else if (cnt_q == 5'd16) begin
            wen_d    = 1'b1;
            waddr_d  = 4'd15;
            wdata_d  = 6'd1;
            gstate_d = 2'd1;
            cnt_d    = 5'd17;
          end else begin
            state_d = S_EDIT;
          end
        end
        S_EDIT: begin
          if (BTN_SUBMIT) begin
            state_d = S_SCORE;
            sc_d    = '0;
            sum_d   = '0;
          end else if (BTN_MOVE) begin
            cursor_d = cursor_q + 2'd1;
          end else if (BTN_NEXT) begin
            guess_d[cursor_q] = (guess_q[cursor_q] == 3'd5) ? 3'd0 : guess_q[cursor_q] + 3'd1;
            wen_d   = 1'b1;
            waddr_d = word_addr(row_q, cursor_q[1]);
            wdata_d = cursor_q[1] ? {guess_d[3], guess_d[2]} : {guess_d[1], guess_d[0]};
          end
        end
        S_SCORE: begin
          if (sc_q == 3'd0) begin
            black_d = blk;
            sc_d    = 3'd1;
          end else begin
            sum_d = sum_nx;
            if (sc_q == 3'd6) begin
              state_d  = S_RESULT;
              wen_d    = 1'b1;
              waddr_d  = word_addr(row_q, 1'b0) + 4'd2;
              wdata_d  = {black_q, sum_nx - black_q};
              hits_d   = black_q;
              misses_d = sum_nx - black_q;
            end else begin
              sc_d = sc_q + 3'd1;
            end
          end
        end
        S_RESULT: begin
          state_d = S_FINISH;
          if (black_q == 3'd4) begin
            wen_d    = 1'b1;
            waddr_d  = 4'd15;
            wdata_d  = 6'd2;
            gstate_d = 2'd2;
          end else if (row_q == 3'(ROWS - 1)) begin
            wen_d    = 1'b1;
            waddr_d  = 4'd15;
            wdata_d  = 6'd3;
            gstate_d = 2'd3;
          end else begin
            row_d    = row_q + 3'd1;
            cursor_d = '0;
            guess_d  = '0;
          end
        end
        S_FINISH: state_d = (gstate_q == 2'd1) ? S_EDIT : S_DONE;
        default: ;
      endcase
    end
    busy_d = (state_d == S_CLEAR) || (state_d == S_SCORE) ||
             (state_d == S_RESULT) || (state_d == S_FINISH);
  end

  always_ff @(posedge CLK_PLL or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      cursor_q <= '0;
      row_q    <= '0;
      sc_q     <= '0;
      black_q  <= '0;
      sum_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      gstate_q <= '0;
      cnt_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      cursor_q <= cursor_d;
      row_q    <= row_d;
      sc_q     <= sc_d;
      black_q  <= black_d;
      sum_q    <= sum_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      gstate_q <= gstate_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
    end
  end

  assign RAM_WADDR  = waddr_q;
  assign RAM_WDATA  = wdata_q;
  assign RAM_WEN    = wen_q;
  assign CURSOR     = cursor_q;
  assign ROW        = row_q;
  assign HITS       = hits_q;
  assign MISSES     = misses_q;
  assign GAME_STATE = gstate_q;
  assign BUSY       = busy_q;
endmodule

// File: tb/tb_mastermind_game.sv
// Scoreboarded bench for mastermind_game: every expected RAM write (addr, data, cycle)
// is queued when stimulus is driven and matched against the write port.
module tb_mastermind_game;
  logic        CLK_PLL = 1'b0, RST_N = 1'b0;
  logic        NEW_GAME = 1'b0, BTN_NEXT = 1'b0, BTN_MOVE = 1'b0, BTN_SUBMIT = 1'b0;
  logic [11:0] SECRET = '0;
  logic [3:0]  RAM_WADDR;
  logic [5:0]  RAM_WDATA;
  logic        RAM_WEN, BUSY;
  logic [1:0]  CURSOR, GAME_STATE;
  logic [2:0]  ROW, HITS, MISSES;

  mastermind_game #(.ROWS(5), .PEGS(4)) dut (
    .CLK_PLL(CLK_PLL), .RST_N(RST_N), .NEW_GAME(NEW_GAME), .SECRET(SECRET),
    .BTN_NEXT(BTN_NEXT), .BTN_MOVE(BTN_MOVE), .BTN_SUBMIT(BTN_SUBMIT),
    .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_WEN(RAM_WEN),
    .CURSOR(CURSOR), .ROW(ROW), .HITS(HITS), .MISSES(MISSES),
    .GAME_STATE(GAME_STATE), .BUSY(BUSY)
  );

  always #5 CLK_PLL = ~CLK_PLL;

  int cyc = 0;
  always @(posedge CLK_PLL) cyc <= cyc + 1;

  typedef struct { logic [3:0] a; logic [5:0] d; int c; } wr_t;
  wr_t q[$];
  int checks = 0, errors = 0;

  logic [3:0][2:0] m_sec, m_gue;
  logic [1:0]      m_cur;
  logic [2:0]      m_row;
  logic [1:0]      m_gs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [5:0] d, input int c);
    wr_t e;
    e.a = a; e.d = d; e.c = c;
    q.push_back(e);
  endtask

  always @(negedge CLK_PLL) begin
    if (RST_N && RAM_WEN) begin
      chk("wr_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(RAM_WADDR), 32'(e.a));
        chk("wr_data", 32'(RAM_WDATA), 32'(e.d));
        chk("wr_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK_PLL); #1; end
  endtask

  task automatic btn(input logic ng, input logic nx, input logic mv, input logic sb);
    NEW_GAME = ng; BTN_NEXT = nx; BTN_MOVE = mv; BTN_SUBMIT = sb;
    tick(1);
    NEW_GAME = 0; BTN_NEXT = 0; BTN_MOVE = 0; BTN_SUBMIT = 0;
  endtask

  function automatic logic [3:0] waddr(input logic [2:0] r, input int off);
    return 4'(3 * int'(r) + off);
  endfunction

  task automatic new_game(input logic [2:0] p0, p1, p2, p3);
    int t;
    logic [3:0][2:0] raw;
    t = cyc;
    while (q.size() > 0 && q[$].c > t) void'(q.pop_back());
    raw = {p3, p2, p1, p0};
    for (int k = 0; k < 4; k++) m_sec[k] = (raw[k] > 3'd5) ? raw[k] - 3'd6 : raw[k];
    m_gue = '0; m_cur = 0; m_row = 0; m_gs = 1;
    for (int i = 0; i < 16; i++) push(4'(i), 6'd0, t + 1 + i);
    push(4'd15, 6'd1, t + 17);
    SECRET = raw;
    btn(1, 0, 0, 0);
    chk("clear_busy", 32'(BUSY), 1);
    tick(17);
    chk("clear_gs", 32'(GAME_STATE), 1);
    chk("clear_busy_end", 32'(BUSY), 0);
    chk("clear_row", 32'(ROW), 0);
  endtask

  task automatic next();
    int w;
    m_gue[m_cur] = (m_gue[m_cur] == 3'd5) ? 3'd0 : m_gue[m_cur] + 3'd1;
    w = int'(m_cur[1]);
    push(waddr(m_row, w), {m_gue[2*w+1], m_gue[2*w]}, cyc + 1);
    btn(0, 1, 0, 0);
  endtask

  task automatic move();
    m_cur = m_cur + 2'd1;
    btn(0, 0, 1, 0);
    chk("cursor", 32'(CURSOR), 32'(m_cur));
  endtask

  task automatic enter(input int g0, g1, g2, g3);
    int g[4];
    g = '{g0, g1, g2, g3};
    for (int k = 0; k < 4; k++) begin
      repeat (g[k]) next();
      move();
    end
  endtask

  // Reference scoring by pairing off pegs, independent of the colour-count method
  task automatic score(output int b, output int w);
    logic [3:0] us, ug;
    b = 0; w = 0; us = '0; ug = '0;
    for (int k = 0; k < 4; k++)
      if (m_gue[k] == m_sec[k]) begin b++; us[k] = 1; ug[k] = 1; end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!ug[i] && !us[j] && m_gue[i] == m_sec[j]) begin ug[i] = 1; us[j] = 1; w++; end
  endtask

  task automatic submit(input logic with_move);
    int t, b, w;
    t = cyc;
    score(b, w);
    push(waddr(m_row, 2), {3'(b), 3'(w)}, t + 8);
    if (b == 4) begin m_gs = 2; push(4'd15, 6'd2, t + 9); end
    else if (m_row == 3'd4) begin m_gs = 3; push(4'd15, 6'd3, t + 9); end
    btn(0, 0, with_move, 1);
    chk("score_busy", 32'(BUSY), 1);
    tick(8);
    chk("hits", 32'(HITS), 32'(b));
    chk("misses", 32'(MISSES), 32'(w));
    chk("game_state", 32'(GAME_STATE), 32'(m_gs));
    tick(1);
    if (m_gs == 1) begin m_row++; m_gue = '0; m_cur = 0; end
    chk("row", 32'(ROW), 32'(m_row));
    chk("cursor_after", 32'(CURSOR), 32'(m_cur));
    chk("busy_after", 32'(BUSY), 0);
  endtask

  initial begin
    tick(3);
    chk("rst_wen", 32'(RAM_WEN), 0);
    chk("rst_gs", 32'(GAME_STATE), 0);
    chk("rst_outs", 32'({RAM_WADDR, RAM_WDATA, CURSOR, ROW, HITS, MISSES, BUSY}), 0);
    RST_N = 1;
    tick(2);
    btn(0, 1, 0, 0);
    btn(0, 0, 1, 0);
    tick(2);
    chk("idle_cursor", 32'(CURSOR), 0);

    // Immediate win, then buttons in DONE must be inert
    new_game(0, 1, 2, 3);
    enter(0, 1, 2, 3);
    submit(0);
    btn(0, 1, 0, 0); btn(0, 0, 1, 0); btn(0, 0, 0, 1);
    tick(12);
    chk("done_gs", 32'(GAME_STATE), 2);
    chk("done_cursor", 32'(CURSOR), 0);

    // All-white result
    new_game(0, 1, 2, 3);
    enter(3, 2, 1, 0);
    submit(0);

    // Mixed black/white with repeated colours
    new_game(1, 1, 2, 2);
    enter(1, 2, 1, 0);
    submit(0);

    // Five misses -> lost
    new_game(5, 4, 3, 2);
    submit(0);
    enter(2, 3, 4, 5); submit(0);
    enter(5, 4, 3, 3); submit(0);
    enter(1, 1, 1, 1); submit(0);
    enter(5, 4, 2, 3); submit(0);
    tick(3);
    chk("lost_gs", 32'(GAME_STATE), 3);

    // Colour wrap, SUBMIT beating MOVE, SECRET fields 7/6 reduced
    new_game(7, 6, 2, 3);
    repeat (6) next();
    submit(1);
    enter(1, 0, 2, 3);
    submit(0);

    // NEW_GAME during SCORE aborts without a feedback write
    new_game(0, 1, 2, 3);
    enter(1, 0, 0, 0);
    btn(0, 0, 0, 1);
    tick(2);
    new_game(0, 1, 2, 3);
    enter(0, 1, 2, 3);
    submit(0);

    // Reset in the middle of scoring
    new_game(2, 2, 2, 2);
    enter(2, 0, 0, 0);
    btn(0, 0, 0, 1);
    tick(3);
    RST_N = 0;
    q.delete();
    #1;
    chk("mid_rst_wen", 32'(RAM_WEN), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_gs", 32'(GAME_STATE), 0);
    tick(2);
    RST_N = 1;
    tick(1);
    btn(0, 1, 0, 0);
    tick(12);
    chk("post_rst_row", 32'(ROW), 0);

    chk("sb_drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
